// File: rtl/utils_mul_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package utils_mul_pkg;

  localparam int CL_SLICE = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/utils_mul_cla_add.sv
// WIDTH-bit adder made of chained 8-bit carry-lookahead slices.
// Purely combinational; each slice's top carry feeds the next slice's carry-in.
module utils_mul_cla_add
  import utils_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  localparam int NSL = WIDTH / CL_SLICE;

  logic [NSL:0] c;

  assign c[0] = ci;

  for (genvar s = 0; s < NSL; s++) begin : g_slice
    logic [CL_SLICE-1:0] g, p, x;
    logic [CL_SLICE:0]   cc;

    assign g = a[s*CL_SLICE +: CL_SLICE] & b[s*CL_SLICE +: CL_SLICE];
    assign p = a[s*CL_SLICE +: CL_SLICE] | b[s*CL_SLICE +: CL_SLICE];
    assign x = a[s*CL_SLICE +: CL_SLICE] ^ b[s*CL_SLICE +: CL_SLICE];

    // Flattened lookahead: carry i+1 is the OR of every generate (or the
    // slice carry-in) propagated through all higher positions up to i.
    always_comb begin
      logic t;
      cc    = '0;
      cc[0] = c[s];
      for (int i = 0; i < CL_SLICE; i++) begin
        for (int j = 0; j <= i + 1; j++) begin
          // NOTE: blocking '=' in always_comb; t is a scratch term rebuilt each pass.
          t = (j == 0) ? c[s] : g[j-1];
          for (int k = j; k <= i; k++) t = t & p[k];
          cc[i+1] = cc[i+1] | t;
        end
      end
    end

    assign sum[s*CL_SLICE +: CL_SLICE] = x ^ cc[CL_SLICE-1:0];
    assign c[s+1] = cc[CL_SLICE];
  end

  assign co = c[NSL];

endmodule

// File: rtl/utils_mul_seq_ctrl.sv
// Sequencing controller for a WIDTH-iteration unsigned shift-add multiplier.
// Optional build macro MUL_SEQ_ZERO_SKIP_EN: zero operands bypass RUN and finish in one cycle.
module utils_mul_seq_ctrl
  import utils_mul_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  if ((WIDTH % CL_SLICE) != 0 || WIDTH < CL_SLICE) begin : g_bad_width
    $error("utils_mul_seq_ctrl: WIDTH must be a multiple of 8 and >= 8");
  end

  mul_state_e         state;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [CNT_W-1:0]   count;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               co;

  assign addend = acc[0] ? mcand : '0;

  utils_mul_cla_add #(.WIDTH(WIDTH)) u_add (
    .a   (acc[2*WIDTH-1:WIDTH]),
    .b   (addend),
    .ci  (1'b0),
    .sum (sum),
    .co  (co)
  );

  // The product register doubles as the output; it is only meaningful in DONE.
  assign out_p = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking '<=' for all sequential state; every register here is plain flops, so all are reset.
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      count     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mcand    <= in_a;
            count    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef MUL_SEQ_ZERO_SKIP_EN
            if (in_a == '0 || in_b == '0) begin
              acc       <= '0;
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              acc   <= {{WIDTH{1'b0}}, in_b};
              state <= RUN;
            end
`else
            acc   <= {{WIDTH{1'b0}}, in_b};
            state <= RUN;
`endif
          end
        end
        RUN: begin
          // Right shift that keeps the adder carry as the new MSB.
          acc   <= {co, sum, acc[WIDTH-1:1]};
          count <= count + 1'b1;
          if (count == CNT_W'(WIDTH - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_utils_mul_seq_ctrl.sv
// Scoreboard bench for utils_mul_seq_ctrl (WIDTH=8 main instance, WIDTH=16 carry instance).
module tb_utils_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_p;
  logic        busy;

  logic        w16_in_valid = 1'b0;
  logic        w16_in_ready;
  logic [15:0] w16_in_a = '0;
  logic [15:0] w16_in_b = '0;
  logic        w16_out_valid;
  logic        w16_out_ready = 1'b1;
  logic [31:0] w16_out_p;
  logic        w16_busy;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  utils_mul_seq_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .busy(busy)
  );

  utils_mul_seq_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(w16_in_valid), .in_ready(w16_in_ready), .in_a(w16_in_a), .in_b(w16_in_b),
    .out_valid(w16_out_valid), .out_ready(w16_out_ready), .out_p(w16_out_p), .busy(w16_busy)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (out_p !== 16'h0000) begin miscompares++; $display("FAIL reset_out_p got %h want 0000", out_p); end
  endtask

  // One full transaction: accept, wait for result, hold out_ready low for 'hold' cycles, release.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold, input int exp_lat, input string name);
    int          lat;
    logic [15:0] exp;
    @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL %s accept_ready got %b want 1", name, in_ready); end
    in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
    exp_q.push_back({8'd0, a} * {8'd0, b});
    @(negedge clk);
    in_valid = 1'b0;
    in_a = 8'hA5; in_b = 8'h3C;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    vectors++; if (lat != exp_lat) begin miscompares++; $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat); end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    vectors++; if (out_p !== exp) begin miscompares++; $display("FAIL %s out_p got %h want %h", name, out_p, exp); end
    vectors++; if (busy !== 1'b1 || in_ready !== 1'b0) begin miscompares++; $display("FAIL %s done_flags busy=%b in_ready=%b want 1/0", name, busy, in_ready); end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_p !== exp || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL %s hold%0d valid=%b p=%h in_ready=%b want 1/%h/0", name, i, out_valid, out_p, in_ready, exp);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s release in_ready=%b out_valid=%b busy=%b want 1/0/0", name, in_ready, out_valid, busy);
    end
  endtask

  task automatic test_basic();
    run_op(8'd13, 8'd11, 0, 9, "basic");
  endtask

  task automatic test_max_carry();
    run_op(8'd255, 8'd255, 0, 9, "max8");
  endtask

  task automatic test_max_carry_w16();
    int lat;
    @(negedge clk);
    w16_in_a = 16'hFFFF; w16_in_b = 16'hFFFF; w16_in_valid = 1'b1; w16_out_ready = 1'b0;
    @(negedge clk);
    w16_in_valid = 1'b0;
    lat = 1;
    while (w16_out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    vectors++; if (lat != 17) begin miscompares++; $display("FAIL max16 latency got %0d want 17", lat); end
    vectors++; if (w16_out_p !== 32'hFFFE0001) begin miscompares++; $display("FAIL max16 out_p got %h want fffe0001", w16_out_p); end
    w16_out_ready = 1'b1;
    @(negedge clk);
    vectors++; if (w16_in_ready !== 1'b1 || w16_busy !== 1'b0) begin miscompares++; $display("FAIL max16 release in_ready=%b busy=%b want 1/0", w16_in_ready, w16_busy); end
  endtask

  task automatic test_backpressure();
    run_op(8'd200, 8'd3, 5, 9, "backpressure");
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    in_a = 8'd9; in_b = 8'd9; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_p !== 16'h0000) begin
      miscompares++;
      $display("FAIL midreset in_ready=%b busy=%b out_valid=%b out_p=%h want 1/0/0/0000", in_ready, busy, out_valid, out_p);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_spurious cycle%0d out_valid=%b want 0", i, out_valid); end
    end
    run_op(8'd7, 8'd6, 0, 9, "after_reset");
  endtask

  task automatic test_zero_operand();
`ifdef MUL_SEQ_ZERO_SKIP_EN
    run_op(8'd0, 8'h5A, 0, 1, "zero_a");
    run_op(8'h5A, 8'd0, 1, 1, "zero_b");
`else
    run_op(8'd0, 8'h5A, 0, 9, "zero_a");
    run_op(8'h5A, 8'd0, 1, 9, "zero_b");
`endif
  endtask

  task automatic test_back_to_back();
    int          sent = 0;
    int          got = 0;
    int          cyc = 0;
    logic        accepted = 1'b0;
    logic [15:0] exp;
    in_valid = 1'b0;
    while ((sent < 1000 || got < 1000) && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (accepted) begin
        in_valid = 1'b0;
        accepted = 1'b0;
      end
      if (!in_valid && sent < 1000 && $urandom_range(3) != 0) begin
        in_a = 8'($urandom);
        in_b = 8'($urandom);
        if ($urandom_range(15) == 0) in_a = 8'd0;
        if ($urandom_range(15) == 0) in_b = 8'd0;
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(1) == 1);
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back({8'd0, in_a} * {8'd0, in_b});
        sent++;
        accepted = 1'b1;
      end
      if (out_valid === 1'b1 && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL b2b_duplicate result %h with empty scoreboard", out_p);
        end else begin
          exp = exp_q.pop_front();
          if (out_p !== exp) begin miscompares++; $display("FAIL b2b_product #%0d got %h want %h", got, out_p, exp); end
        end
        got++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    vectors++; if (sent != 1000 || got != 1000) begin miscompares++; $display("FAIL b2b_count sent=%0d got=%0d want 1000/1000", sent, got); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_leftover got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_carry();
    test_max_carry_w16();
    test_backpressure();
    test_reset_mid_op();
    test_zero_operand();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
